// File: rtl/elevator_ctrl_n.sv
// elevator_ctrl_n: N-floor elevator controller with SCAN sweeps,
// sticky call latching, a per-floor travel timer and a timed door phase.
module elevator_ctrl_n #(
  parameter int FLOORS     = 8,
  parameter int FLOOR_W    = 3,
  parameter int TRAVEL_CYC = 4,
  parameter int DOOR_CYC   = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [FLOORS-1:0]  req,
  output logic [FLOOR_W-1:0] floor,
  output logic               dir,
  output logic               moving,
  output logic               door_open,
  output logic [FLOORS-1:0]  pending
);

  localparam int TW = (TRAVEL_CYC > 1) ? $clog2(TRAVEL_CYC) : 1;
  localparam int DW = (DOOR_CYC > 1) ? $clog2(DOOR_CYC) : 1;
  localparam logic [TW-1:0] TC_LAST = TW'(TRAVEL_CYC - 1);
  localparam logic [DW-1:0] DC_LAST = DW'(DOOR_CYC - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MOVE,
    S_DOOR
  } state_t;

  state_t             r_state;
  state_t             w_state_nx;
  logic [FLOOR_W-1:0] r_floor;
  logic [FLOOR_W-1:0] w_floor_nx;
  logic [FLOOR_W-1:0] w_floor_adj;
  logic               r_dir;
  logic               w_dir_nx;
  logic [FLOORS-1:0]  r_pend;
  logic [FLOORS-1:0]  w_eff;
  logic [FLOORS-1:0]  w_clr;
  logic [TW-1:0]      r_tcnt;
  logic [TW-1:0]      w_tcnt_nx;
  logic [DW-1:0]      r_dcnt;
  logic [DW-1:0]      w_dcnt_nx;

  function automatic logic f_above(
    input logic [FLOORS-1:0]  v,
    input logic [FLOOR_W-1:0] f
  );
    logic r;
    r = 1'b0;
    for (int i = 0; i < FLOORS; i++)
      if (v[i] && (i > int'(f))) r = 1'b1;
    return r;
  endfunction

  function automatic logic f_below(
    input logic [FLOORS-1:0]  v,
    input logic [FLOOR_W-1:0] f
  );
    logic r;
    r = 1'b0;
    for (int i = 0; i < FLOORS; i++)
      if (v[i] && (i < int'(f))) r = 1'b1;
    return r;
  endfunction

  assign w_eff = r_pend | req;

  // Next state, floor, direction, timers and the service clear
  always_comb begin
    w_state_nx  = r_state;
    w_floor_nx  = r_floor;
    w_dir_nx    = r_dir;
    w_tcnt_nx   = r_tcnt;
    w_dcnt_nx   = r_dcnt;
    w_clr       = '0;
    w_floor_adj = r_dir ? (r_floor + FLOOR_W'(1))
                        : (r_floor - FLOOR_W'(1));
    unique case (r_state)
      S_IDLE: begin
        w_tcnt_nx = '0;
        if (w_eff[r_floor]) begin
          w_state_nx = S_DOOR;
          w_clr      = FLOORS'(1) << r_floor;
          w_dcnt_nx  = DC_LAST;
        end else if (r_dir ? f_above(w_eff, r_floor)
                           : f_below(w_eff, r_floor)) begin
          w_state_nx = S_MOVE;
        end else if (r_dir ? f_below(w_eff, r_floor)
                           : f_above(w_eff, r_floor)) begin
          w_state_nx = S_MOVE;
          w_dir_nx   = ~r_dir;
        end
      end
      S_MOVE: begin
        if (r_tcnt != TC_LAST) begin
          w_tcnt_nx = r_tcnt + TW'(1);
        end else begin
          w_tcnt_nx  = '0;
          w_floor_nx = w_floor_adj;
          if (w_eff[w_floor_adj]) begin
            w_state_nx = S_DOOR;
            w_clr      = FLOORS'(1) << w_floor_adj;
            w_dcnt_nx  = DC_LAST;
          end else if (!(r_dir ? f_above(w_eff, w_floor_adj)
                               : f_below(w_eff, w_floor_adj))) begin
            w_state_nx = S_IDLE;
          end
        end
      end
      S_DOOR: begin
        if (w_eff[r_floor]) begin
          w_clr     = FLOORS'(1) << r_floor;
          w_dcnt_nx = DC_LAST;
        end else if (r_dcnt == '0) begin
          w_state_nx = S_IDLE;
        end else begin
          w_dcnt_nx = r_dcnt - DW'(1);
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  // State and datapath registers; reset overrides any phase
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_floor <= '0;
      r_dir   <= 1'b1;
      r_pend  <= '0;
      r_tcnt  <= '0;
      r_dcnt  <= '0;
    end else begin
      r_state <= w_state_nx;
      r_floor <= w_floor_nx;
      r_dir   <= w_dir_nx;
      r_pend  <= w_eff & ~w_clr;
      r_tcnt  <= w_tcnt_nx;
      r_dcnt  <= w_dcnt_nx;
    end
  end

  assign floor     = r_floor;
  assign dir       = r_dir;
  assign pending   = r_pend;
  assign moving    = (r_state == S_MOVE);
  assign door_open = (r_state == S_DOOR);

endmodule

// File: tb/tb_elevator_ctrl_n.sv
// tb_elevator_ctrl_n: directed scenarios plus random calls, checked
// against a countdown-based car model and per-cycle invariants.
module tb_elevator_ctrl_n;

  localparam int N  = 8;
  localparam int FW = 3;
  localparam int TC = 4;
  localparam int DC = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req;
  logic [FW-1:0] floor;
  logic          dir;
  logic          moving;
  logic          door_open;
  logic [N-1:0]  pending;

  int errs   = 0;
  int checks = 0;

  int       m_floor;
  int       m_phase;
  int       m_t;
  bit       m_dir;
  bit [N-1:0] m_pend;

  logic [FW-1:0] p_floor;
  logic          p_dir;
  logic          p_moving;
  logic          p_door;

  elevator_ctrl_n #(
    .FLOORS(N), .FLOOR_W(FW),
    .TRAVEL_CYC(TC), .DOOR_CYC(DC)
  ) dut (
    .clk(clk), .rst(rst), .req(req),
    .floor(floor), .dir(dir),
    .moving(moving), .door_open(door_open),
    .pending(pending)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(string tag, logic [31:0] got,
                     logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  function automatic bit any_side(bit [N-1:0] v, int f, bit up);
    for (int i = 0; i < N; i++)
      if (v[i] && (up ? (i > f) : (i < f))) return 1'b1;
    return 1'b0;
  endfunction

  // phase 0=idle 1=travel 2=door; m_t = edges left in phase
  task automatic model(bit r, bit [N-1:0] rq);
    bit [N-1:0] eff;
    eff = m_pend | rq;
    if (r) begin
      m_floor = 0; m_dir = 1'b1; m_phase = 0;
      m_t = 0; m_pend = '0;
      return;
    end
    case (m_phase)
      0: begin
        if (eff[m_floor]) begin
          m_phase = 2; m_t = DC; eff[m_floor] = 1'b0;
        end else if (any_side(eff, m_floor, m_dir)) begin
          m_phase = 1; m_t = TC;
        end else if (any_side(eff, m_floor, !m_dir)) begin
          m_dir = !m_dir; m_phase = 1; m_t = TC;
        end
      end
      1: begin
        m_t--;
        if (m_t == 0) begin
          m_floor += m_dir ? 1 : -1;
          if (eff[m_floor]) begin
            m_phase = 2; m_t = DC; eff[m_floor] = 1'b0;
          end else if (any_side(eff, m_floor, m_dir)) begin
            m_t = TC;
          end else begin
            m_phase = 0;
          end
        end
      end
      default: begin
        if (eff[m_floor]) begin
          m_t = DC; eff[m_floor] = 1'b0;
        end else begin
          m_t--;
          if (m_t == 0) m_phase = 0;
        end
      end
    endcase
    m_pend = eff;
  endtask

  task automatic step(bit r, bit [N-1:0] rq);
    rst = r;
    req = rq;
    model(r, rq);
    p_floor  = floor;
    p_dir    = dir;
    p_moving = moving;
    p_door   = door_open;
    @(posedge clk);
    #1;
    chk("floor", floor, m_floor);
    chk("dir", dir, m_dir);
    chk("moving", moving, m_phase == 1);
    chk("door_open", door_open, m_phase == 2);
    chk("pending", pending, m_pend);
    chk("inv_excl", moving & door_open, 0);
    if (!r) begin
      if (floor != p_floor)
        chk("inv_fstep", p_moving &&
            (int'(floor) == int'(p_floor) + 1 ||
             int'(floor) == int'(p_floor) - 1), 1);
      if (dir != p_dir)
        chk("inv_dir", !p_moving && !p_door && moving, 1);
    end
  endtask

  task automatic wait_door(int lim);
    int n = 0;
    while (door_open && n < lim) begin step(0, '0); n++; end
    while (!door_open && n < lim) begin step(0, '0); n++; end
    chk("door_wait", door_open, 1);
  endtask

  task automatic wait_idle(int lim);
    int n = 0;
    while ((moving || door_open) && n < lim) begin
      step(0, '0); n++;
    end
    chk("idle_wait", moving | door_open, 0);
  endtask

  initial begin
    bit [N-1:0] rv;
    int n;
    rst = 1'b1;
    req = '1;

    step(1, '1);
    step(1, '1);
    chk("rst_floor", floor, 0);
    chk("rst_dir", dir, 1);
    chk("rst_pend", pending, 0);
    chk("rst_move", moving, 0);
    chk("rst_door", door_open, 0);
    step(0, '0);
    step(0, '0);
    chk("post_rst_pend", pending, 0);

    step(0, 8'h20);
    chk("t2_moving", moving, 1);
    for (int k = 1; k <= 23; k++) begin
      step(0, '0);
      if (k % 4 == 0 && k <= 20)
        chk("t2_floor", floor, k / 4);
      if (k == 20) chk("t2_pend", pending, 0);
      if (k >= 20 && k <= 22) chk("t2_door", door_open, 1);
      if (k == 23) chk("t2_idle", door_open | moving, 0);
    end

    step(0, 8'h04);
    wait_door(100);
    wait_idle(100);
    chk("t3_floor0", floor, 2);
    step(0, 8'h04);
    chk("t3_door", door_open, 1);
    chk("t3_nomove", moving, 0);
    step(0, '0);
    step(0, 8'h04);
    step(0, '0);
    step(0, '0);
    chk("t3_ext", door_open, 1);
    chk("t3_floor", floor, 2);
    step(0, '0);
    chk("t3_close", door_open, 0);

    step(0, 8'h40);
    n = 0;
    while (floor != 3 && n < 50) begin step(0, '0); n++; end
    chk("t4_at3", floor, 3);
    step(0, 8'h42);
    chk("t4_pend", pending, 8'h42);
    chk("t4_mov", moving, 1);
    wait_door(200);
    chk("t4_f6", floor, 6);
    chk("t4_p02", pending, 8'h02);
    chk("t4_dirup", dir, 1);
    wait_door(200);
    chk("t4_f1", floor, 1);
    chk("t4_p00", pending, 0);
    chk("t4_dirdn", dir, 0);

    step(0, 8'h08);
    wait_door(200);
    chk("t5_f3", floor, 3);
    wait_idle(100);
    step(0, 8'h80);
    chk("t5_leave", moving, 1);
    step(0, 8'h08);
    chk("t5_latch", pending, 8'h88);
    wait_door(200);
    chk("t5_f7", floor, 7);
    chk("t5_keep3", pending, 8'h08);
    wait_door(200);
    chk("t5_back3", floor, 3);
    chk("t5_p00", pending, 0);

    wait_idle(100);
    step(0, 8'h01);
    step(0, '0);
    step(0, '0);
    chk("t6_mid", moving, 1);
    step(1, '0);
    chk("t6_floor", floor, 0);
    chk("t6_pend", pending, 0);
    chk("t6_door", door_open, 0);
    step(0, '0);
    for (int i = 0; i < 50; i++) begin
      rv = N'($urandom);
      step(0, rv);
      step(0, '0);
    end
    n = 0;
    while ((pending != 0 || moving || door_open) && n < 4000) begin
      step(0, '0); n++;
    end
    chk("drain_pend", pending, 0);
    chk("drain_idle", moving | door_open, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
